data_mem_ctrl: RTL

Parametrised data-memory controller for the multicycle RV32I core. It replaces the fixed word-only memory behind the core's load/store path and adds:
- byte/halfword/word access selected by funct3, with sign or zero extension on loads;
- a configurable wait-state latency;
- a valid/ready request/response handshake;
- error reporting for misaligned, out-of-range and illegal accesses.

It sits between the controller/datapath memory port and a word-organised storage array held inside the block.

---
 rtl/data_mem_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the multicycle RV32I core: sized loads/stores with
// configurable wait states, valid/ready handshake and access-error reporting.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    // Storage is never reset; contents survive a reset of the control path.
    logic [31:0] mem [DEPTH_WORDS];

    logic            illegal;
    logic            misaligned;
    logic            out_of_range;
    logic            acc_err;
    logic            access;
    logic            mem_we;
    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     load_data;
    logic [31:0]     wr_word;
    logic [3:0]      be;

    assign idx = addr_q[IdxW+1:2];

    always_comb begin
        if (we_q) begin
            illegal = !(funct3_q inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = funct3_q inside {3'b011, 3'b110, 3'b111};
        end
        misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                       ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        out_of_range = ({2'b00, addr_q[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
        acc_err      = illegal || misaligned || out_of_range;
        access       = (state_q == StWait) && (cnt_q == 4'd0);
        mem_we       = access && we_q && !acc_err;
    end

    always_comb begin
        rd_word = mem[idx];
        ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q[1:0])
            2'b00:   load_data = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = rd_word;
        endcase
    end

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be      = 4'b1111;
        wr_word = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= 4'(WAIT_CYCLES);
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_data;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

endmodule
